wb_regfile: RTL and testbench

//   Writeback-stage consumer of the MEM/WB pipeline register outputs. Selects the

---
 rtl/wb_regfile.sv | 148 ++++++++++++++
 tb/tb_wb_regfile.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file.
// Picks the writeback value (ALU result or load data) and writes the integer
// register file. It also serves two decode read ports with same-cycle write
// bypass, tracks in-flight writes per register for RAW hazard detection, and
// emits a registered commit trace for each completed write.
module wb_regfile #(
  parameter int DATA_WIDTH   = 64,
  parameter int REG_ID_WIDTH = 5,
  parameter int CNT_WIDTH    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_stall,
  input  logic [DATA_WIDTH-1:0]   alu_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [REG_ID_WIDTH-1:0] dest_in,
  input  logic [1:0]              wb_control_in,
  input  logic [REG_ID_WIDTH-1:0] rs1_id,
  input  logic [REG_ID_WIDTH-1:0] rs2_id,
  output logic [DATA_WIDTH-1:0]   rs1_data,
  output logic [DATA_WIDTH-1:0]   rs2_data,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  input  logic                    issue_valid,
  input  logic [REG_ID_WIDTH-1:0] issue_dest,
  output logic                    issue_ready,
  input  logic                    cancel_valid,
  input  logic [REG_ID_WIDTH-1:0] cancel_dest,
  output logic                    commit_valid,
  output logic [REG_ID_WIDTH-1:0] commit_dest,
  output logic [DATA_WIDTH-1:0]   commit_data
);

  localparam int NUM_REGS = 2 ** REG_ID_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [REG_ID_WIDTH-1:0] REG_ZERO = {REG_ID_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_r    [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_r     [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_nxt_s [NUM_REGS];

  logic                  wb_en_s;
  logic [DATA_WIDTH-1:0] wb_data_s;
  logic                  issue_ready_s;

  // Next counter value: add the accepted issue, subtract the retire and cancel,
  // and clamp at zero so a spurious decrement never wraps to "max in flight".
  function automatic logic [CNT_WIDTH-1:0] cnt_update(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 inc,
    input logic                 dec_a,
    input logic                 dec_b
  );
    logic [CNT_WIDTH:0] up;
    logic [CNT_WIDTH:0] dn;
    up = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, inc};
    dn = {{CNT_WIDTH{1'b0}}, dec_a} + {{CNT_WIDTH{1'b0}}, dec_b};
    if (up < dn) begin
      return {CNT_WIDTH{1'b0}};
    end else begin
      return CNT_WIDTH'(up - dn);
    end
  endfunction

  // Writeback enable and value selection; register 0 is never a target.
  always_comb begin
    wb_en_s   = wb_control_in[1] & ~wb_stall & (dest_in != REG_ZERO);
    wb_data_s = wb_control_in[0] ? mem_data_in : alu_in;
  end

  // Issue is refused only when the counter is saturated and nothing retires or cancels it this cycle.
  always_comb begin
    issue_ready_s = 1'b1;
    if (issue_dest == REG_ZERO) begin
      issue_ready_s = 1'b1;
    end else if ((cnt_r[issue_dest] == CNT_MAX) &&
                 !((wb_en_s && (dest_in == issue_dest)) ||
                   (cancel_valid && (cancel_dest == issue_dest)))) begin
      issue_ready_s = 1'b0;
    end else begin
      issue_ready_s = 1'b1;
    end
  end

  assign issue_ready = issue_ready_s;

  // Per-register next counter values; entry 0 stays zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r == 0) begin
        cnt_nxt_s[r] = {CNT_WIDTH{1'b0}};
      end else begin
        cnt_nxt_s[r] = cnt_update(cnt_r[r],
                                  issue_valid & issue_ready_s & (issue_dest == REG_ID_WIDTH'(r)),
                                  wb_en_s & (dest_in == REG_ID_WIDTH'(r)),
                                  cancel_valid & (cancel_dest == REG_ID_WIDTH'(r)));
      end
    end
  end

  // Read ports with same-cycle bypass; a write retiring now is not a hazard.
  always_comb begin
    rs1_data = {DATA_WIDTH{1'b0}};
    rs2_data = {DATA_WIDTH{1'b0}};
    if (rs1_id == REG_ZERO) begin
      rs1_data = {DATA_WIDTH{1'b0}};
    end else if (wb_en_s && (dest_in == rs1_id)) begin
      rs1_data = wb_data_s;
    end else begin
      rs1_data = regs_r[rs1_id];
    end
    if (rs2_id == REG_ZERO) begin
      rs2_data = {DATA_WIDTH{1'b0}};
    end else if (wb_en_s && (dest_in == rs2_id)) begin
      rs2_data = wb_data_s;
    end else begin
      rs2_data = regs_r[rs2_id];
    end
    rs1_busy = (cnt_r[rs1_id] != {CNT_WIDTH{1'b0}}) &
               ~((cnt_r[rs1_id] == CNT_WIDTH'(1)) & wb_en_s & (dest_in == rs1_id));
    rs2_busy = (cnt_r[rs2_id] != {CNT_WIDTH{1'b0}}) &
               ~((cnt_r[rs2_id] == CNT_WIDTH'(1)) & wb_en_s & (dest_in == rs2_id));
  end

  // Register file, scoreboard counters and commit trace state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= {DATA_WIDTH{1'b0}};
        cnt_r[r]  <= {CNT_WIDTH{1'b0}};
      end
      commit_valid <= 1'b0;
      commit_dest  <= {REG_ID_WIDTH{1'b0}};
      commit_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      if (wb_en_s) begin
        regs_r[dest_in] <= wb_data_s;
        commit_dest     <= dest_in;
        commit_data     <= wb_data_s;
      end
      commit_valid <= wb_en_s;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stall;
  logic [63:0] alu_in;
  logic [63:0] mem_data_in;
  logic [4:0]  dest_in;
  logic [1:0]  wb_control_in;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic        cancel_valid;
  logic [4:0]  cancel_dest;
  logic        commit_valid;
  logic [4:0]  commit_dest;
  logic [63:0] commit_data;

  int checks_cnt = 0;
  int errors_cnt = 0;

  wb_regfile dut (
    .clk(clk), .reset(reset), .wb_stall(wb_stall),
    .alu_in(alu_in), .mem_data_in(mem_data_in), .dest_in(dest_in),
    .wb_control_in(wb_control_in), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .cancel_valid(cancel_valid), .cancel_dest(cancel_dest),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_data(commit_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and move just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_stall = 1'b0; alu_in = 64'h0; mem_data_in = 64'h0;
    dest_in = 5'd0; wb_control_in = 2'b00; rs1_id = 5'd0; rs2_id = 5'd0;
    issue_valid = 1'b0; issue_dest = 5'd0; cancel_valid = 1'b0; cancel_dest = 5'd0;
    tick(); tick();
    reset = 1'b0;
    #1;

    // 1: reset state
    for (int i = 0; i < 32; i++) begin
      rs1_id = 5'(i); rs2_id = 5'(31 - i); issue_dest = 5'(i);
      #1;
      check($sformatf("rst_rs1_%0d", i), rs1_data, 64'h0);
      check($sformatf("rst_rs2_%0d", i), rs2_data, 64'h0);
      check($sformatf("rst_busy_%0d", i), {63'h0, rs1_busy | rs2_busy}, 64'h0);
      check($sformatf("rst_ready_%0d", i), {63'h0, issue_ready}, 64'h1);
    end
    check("rst_commit_valid", {63'h0, commit_valid}, 64'h0);

    // 2: ALU writeback with bypass
    wb_control_in = 2'b10; dest_in = 5'd5; alu_in = 64'hDEAD_BEEF; mem_data_in = 64'h5555;
    rs1_id = 5'd5; rs2_id = 5'd5;
    #1;
    check("byp_rs1", rs1_data, 64'hDEAD_BEEF);
    check("byp_rs2", rs2_data, 64'hDEAD_BEEF);
    tick();
    wb_control_in = 2'b00; alu_in = 64'h0;
    #1;
    check("wr5_rs1", rs1_data, 64'hDEAD_BEEF);
    check("wr5_cvalid", {63'h0, commit_valid}, 64'h1);
    check("wr5_cdest", {59'h0, commit_dest}, 64'd5);
    check("wr5_cdata", commit_data, 64'hDEAD_BEEF);
    check("wr5_busy_sat", {63'h0, rs1_busy}, 64'h0);
    tick();
    check("idle_cvalid", {63'h0, commit_valid}, 64'h0);

    // 3: load writeback, then write to x0
    wb_control_in = 2'b11; alu_in = 64'h1; mem_data_in = 64'h1234; dest_in = 5'd7;
    rs1_id = 5'd7; rs2_id = 5'd5;
    #1;
    check("ld_byp_rs1", rs1_data, 64'h1234);
    check("ld_other_rs2", rs2_data, 64'hDEAD_BEEF);
    tick();
    wb_control_in = 2'b00;
    #1;
    check("ld_rs1", rs1_data, 64'h1234);
    check("ld_cdata", commit_data, 64'h1234);
    wb_control_in = 2'b10; dest_in = 5'd0; alu_in = 64'hFFFF; rs1_id = 5'd0;
    #1;
    check("x0_byp", rs1_data, 64'h0);
    tick();
    wb_control_in = 2'b00;
    #1;
    check("x0_rd", rs1_data, 64'h0);
    check("x0_cvalid", {63'h0, commit_valid}, 64'h0);
    check("x0_cdest_hold", {59'h0, commit_dest}, 64'd7);
    check("x0_cdata_hold", commit_data, 64'h1234);

    // 4: scoreboard saturation
    issue_valid = 1'b1; issue_dest = 5'd9; rs1_id = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("iss9_ready_%0d", i), {63'h0, issue_ready}, 64'h1);
      tick();
    end
    issue_valid = 1'b0;
    #1;
    check("sat_busy", {63'h0, rs1_busy}, 64'h1);
    check("sat_ready", {63'h0, issue_ready}, 64'h0);
    issue_valid = 1'b1; wb_control_in = 2'b10; dest_in = 5'd9; alu_in = 64'h99;
    #1;
    check("sat_retire_ready", {63'h0, issue_ready}, 64'h1);
    check("sat_retire_busy", {63'h0, rs1_busy}, 64'h1);
    tick();
    issue_valid = 1'b0; wb_control_in = 2'b00;
    #1;
    check("sat_hold_ready", {63'h0, issue_ready}, 64'h0);
    check("sat_hold_busy", {63'h0, rs1_busy}, 64'h1);
    check("sat_rd9", rs1_data, 64'h99);
    cancel_valid = 1'b1; cancel_dest = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check($sformatf("cancel_busy_%0d", i), {63'h0, rs1_busy}, (i < 2) ? 64'h1 : 64'h0);
    end
    cancel_valid = 1'b0;
    #1;
    check("cancel_ready", {63'h0, issue_ready}, 64'h1);

    // 5: stall suppresses write, retire, commit and bypass
    issue_valid = 1'b1; issue_dest = 5'd3;
    tick();
    issue_valid = 1'b0;
    wb_stall = 1'b1; wb_control_in = 2'b10; dest_in = 5'd3; alu_in = 64'h33; rs1_id = 5'd3;
    #1;
    check("stall_nobyp", rs1_data, 64'h0);
    check("stall_busy", {63'h0, rs1_busy}, 64'h1);
    tick();
    check("stall_cvalid", {63'h0, commit_valid}, 64'h0);
    check("stall_rd3", rs1_data, 64'h0);
    check("stall_busy2", {63'h0, rs1_busy}, 64'h1);
    wb_stall = 1'b0;
    #1;
    check("unstall_byp", rs1_data, 64'h33);
    check("unstall_busy", {63'h0, rs1_busy}, 64'h0);
    tick();
    wb_control_in = 2'b00;
    #1;
    check("unstall_cvalid", {63'h0, commit_valid}, 64'h1);
    check("unstall_cdest", {59'h0, commit_dest}, 64'd3);
    check("unstall_rd3", rs1_data, 64'h33);
    check("unstall_busy2", {63'h0, rs1_busy}, 64'h0);

    // 6: reset mid-operation
    issue_valid = 1'b1; issue_dest = 5'd4;
    tick(); tick();
    issue_valid = 1'b0;
    rs1_id = 5'd4;
    #1;
    check("pre_rst_busy", {63'h0, rs1_busy}, 64'h1);
    reset = 1'b1; wb_control_in = 2'b10; dest_in = 5'd4; alu_in = 64'h44; rs2_id = 5'd5;
    #1;
    check("rst_cycle_byp", rs1_data, 64'h44);
    check("rst_cycle_rs2", rs2_data, 64'hDEAD_BEEF);
    tick();
    reset = 1'b0; wb_control_in = 2'b00;
    #1;
    check("post_rst_busy", {63'h0, rs1_busy}, 64'h0);
    check("post_rst_rd4", rs1_data, 64'h0);
    check("post_rst_rd5", rs2_data, 64'h0);
    check("post_rst_ready", {63'h0, issue_ready}, 64'h1);
    check("post_rst_cvalid", {63'h0, commit_valid}, 64'h0);
    check("post_rst_cdest", {59'h0, commit_dest}, 64'h0);
    check("post_rst_cdata", commit_data, 64'h0);
    rs2_id = 5'd7;
    #1;
    check("post_rst_rd7", rs2_data, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
